// File: rtl/ex_branch_latch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | simplerisc_pkg : shared widths, ra index and EX/MA latch record  |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package simplerisc_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  localparam logic [REG_W-1:0] c_ra_idx = 4'd15;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] op2;
    logic [REG_W-1:0]  rd;
    logic              is_ld;
    logic              is_st;
    logic              is_wb;
    logic              is_call;
  } exma_t;

endpackage
`default_nettype wire

// File: rtl/ex_branch_latch_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_branch_latch_if : EX-stage inputs, EX/MA latch and redirect    |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface ex_branch_latch_if;
  import simplerisc_pkg::*;

  logic              stall_i;
  logic              valid_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] branch_target_i;
  logic [DATA_W-1:0] op1_i;
  logic [DATA_W-1:0] op2_i;
  logic [REG_W-1:0]  rd_i;
  logic [DATA_W-1:0] alu_result_i;
  logic              flags_e_i;
  logic              flags_gt_i;
  logic              is_cmp_i;
  logic              is_beq_i;
  logic              is_bgt_i;
  logic              is_ubranch_i;
  logic              is_ret_i;
  logic              is_ld_i;
  logic              is_st_i;
  logic              is_wb_i;
  logic              is_call_i;

  logic              valid_o;
  logic [DATA_W-1:0] pc_o;
  logic [DATA_W-1:0] alu_result_o;
  logic [DATA_W-1:0] op2_o;
  logic [REG_W-1:0]  rd_o;
  logic              is_ld_o;
  logic              is_st_o;
  logic              is_wb_o;
  logic              is_call_o;
  logic              flags_e_o;
  logic              flags_gt_o;
  logic              branch_taken_o;
  logic [DATA_W-1:0] branch_pc_o;
  logic              flush_o;
  logic [31:0]       branch_cnt_o;
  logic [31:0]       taken_cnt_o;

  modport slave (
    input  stall_i, valid_i, pc_i, branch_target_i, op1_i, op2_i, rd_i,
           alu_result_i, flags_e_i, flags_gt_i, is_cmp_i, is_beq_i,
           is_bgt_i, is_ubranch_i, is_ret_i, is_ld_i, is_st_i, is_wb_i,
           is_call_i,
    output valid_o, pc_o, alu_result_o, op2_o, rd_o, is_ld_o, is_st_o,
           is_wb_o, is_call_o, flags_e_o, flags_gt_o, branch_taken_o,
           branch_pc_o, flush_o, branch_cnt_o, taken_cnt_o
  );

  modport master (
    output stall_i, valid_i, pc_i, branch_target_i, op1_i, op2_i, rd_i,
           alu_result_i, flags_e_i, flags_gt_i, is_cmp_i, is_beq_i,
           is_bgt_i, is_ubranch_i, is_ret_i, is_ld_i, is_st_i, is_wb_i,
           is_call_i,
    input  valid_o, pc_o, alu_result_o, op2_o, rd_o, is_ld_o, is_st_o,
           is_wb_o, is_call_o, flags_e_o, flags_gt_o, branch_taken_o,
           branch_pc_o, flush_o, branch_cnt_o, taken_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/ex_branch_latch_branch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_unit : combinational branch decision and redirect target   |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module branch_unit
  import simplerisc_pkg::*;
(
  input  logic              i_fire,
  input  logic              i_flag_e,
  input  logic              i_flag_gt,
  input  logic              i_is_beq,
  input  logic              i_is_bgt,
  input  logic              i_is_ubranch,
  input  logic              i_is_ret,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_target,
  output logic              o_taken,
  output logic [DATA_W-1:0] o_pc
);

  // Flags come from the register, so a cmp in the same slot never affects this.
  assign o_taken = i_fire & (i_is_ubranch | (i_is_beq & i_flag_e) | (i_is_bgt & i_flag_gt));
  assign o_pc    = i_is_ret ? i_op1 : i_target;

endmodule
`default_nettype wire

// File: rtl/ex_branch_latch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_branch_latch : EX back end - flags, branch redirect, EX/MA     |
// | latch. Optional BRANCH_STATS_EN adds branch/taken counters.       |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module ex_branch_latch
  import simplerisc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  ex_branch_latch_if.slave bus
);

  logic              w_fire;
  logic              w_taken;
  logic [DATA_W-1:0] w_bpc;

  logic  flags_e_q, flags_e_d;
  logic  flags_gt_q, flags_gt_d;
  exma_t latch_q, latch_d;

  // Gated by reset so no redirect leaks out while state is being cleared.
  assign w_fire = bus.valid_i & ~bus.stall_i & ~reset;

  branch_unit u_branch_unit (
    .i_fire       (w_fire),
    .i_flag_e     (flags_e_q),
    .i_flag_gt    (flags_gt_q),
    .i_is_beq     (bus.is_beq_i),
    .i_is_bgt     (bus.is_bgt_i),
    .i_is_ubranch (bus.is_ubranch_i),
    .i_is_ret     (bus.is_ret_i),
    .i_op1        (bus.op1_i),
    .i_target     (bus.branch_target_i),
    .o_taken      (w_taken),
    .o_pc         (w_bpc)
  );

  always_comb begin
    flags_e_d  = flags_e_q;
    flags_gt_d = flags_gt_q;
    if (w_fire & bus.is_cmp_i) begin
      flags_e_d  = bus.flags_e_i;
      flags_gt_d = bus.flags_gt_i;
    end
  end

  always_comb begin
    latch_d = latch_q;
    if (!bus.stall_i) begin
      latch_d.valid   = bus.valid_i;
      latch_d.pc      = bus.pc_i;
      latch_d.result  = bus.alu_result_i;
      latch_d.op2     = bus.op2_i;
      latch_d.rd      = bus.rd_i;
      latch_d.is_ld   = bus.is_ld_i   & bus.valid_i;
      latch_d.is_st   = bus.is_st_i   & bus.valid_i;
      latch_d.is_wb   = bus.is_wb_i   & bus.valid_i;
      latch_d.is_call = bus.is_call_i & bus.valid_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_e_q  <= 1'b0;
      flags_gt_q <= 1'b0;
      latch_q    <= '0;
    end else begin
      flags_e_q  <= flags_e_d;
      flags_gt_q <= flags_gt_d;
      latch_q    <= latch_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (w_fire & (bus.is_beq_i | bus.is_bgt_i | bus.is_ubranch_i))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (w_taken)
      taken_cnt_d = taken_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.branch_cnt_o = branch_cnt_q;
  assign bus.taken_cnt_o  = taken_cnt_q;
`else
  assign bus.branch_cnt_o = 32'd0;
  assign bus.taken_cnt_o  = 32'd0;
`endif

  assign bus.valid_o        = latch_q.valid;
  assign bus.pc_o           = latch_q.pc;
  assign bus.alu_result_o   = latch_q.result;
  assign bus.op2_o          = latch_q.op2;
  assign bus.rd_o           = latch_q.rd;
  assign bus.is_ld_o        = latch_q.is_ld;
  assign bus.is_st_o        = latch_q.is_st;
  assign bus.is_wb_o        = latch_q.is_wb;
  assign bus.is_call_o      = latch_q.is_call;
  assign bus.flags_e_o      = flags_e_q;
  assign bus.flags_gt_o     = flags_gt_q;
  assign bus.branch_taken_o = w_taken;
  assign bus.flush_o        = w_taken;
  assign bus.branch_pc_o    = reset ? '0 : w_bpc;

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_latch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ex_branch_latch : directed table, corner sequences and random  |
// | stimulus against a reference model of the EX back end.           |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_ex_branch_latch;
  import simplerisc_pkg::*;

  typedef struct packed {
    logic              stall, valid;
    logic [DATA_W-1:0] pc, tgt, op1, op2, res;
    logic [REG_W-1:0]  rd;
    logic              fe, fgt, cmp, beq, bgt, ub, ret, ld, st, wb, call;
  } in_t;

  typedef struct packed {
    in_t               stim;
    logic              x_taken;
    logic [DATA_W-1:0] x_bpc;
    logic              x_fe, x_fgt, x_valid;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ex_branch_latch_if bus ();

  ex_branch_latch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: architectural flags, the last record accepted into MA, counters
  logic        m_e, m_gt;
  in_t         m_lat;
  logic [31:0] m_bcnt, m_tcnt;

  logic              s_taken, s_fe, s_fgt, s_valid, s_call;
  logic [DATA_W-1:0] s_pc, s_bpc;
  logic [31:0]       s_bcnt, s_tcnt;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    bus.stall_i         = v.stall;
    bus.valid_i         = v.valid;
    bus.pc_i            = v.pc;
    bus.branch_target_i = v.tgt;
    bus.op1_i           = v.op1;
    bus.op2_i           = v.op2;
    bus.alu_result_i    = v.res;
    bus.rd_i            = v.rd;
    bus.flags_e_i       = v.fe;
    bus.flags_gt_i      = v.fgt;
    bus.is_cmp_i        = v.cmp;
    bus.is_beq_i        = v.beq;
    bus.is_bgt_i        = v.bgt;
    bus.is_ubranch_i    = v.ub;
    bus.is_ret_i        = v.ret;
    bus.is_ld_i         = v.ld;
    bus.is_st_i         = v.st;
    bus.is_wb_i         = v.wb;
    bus.is_call_i       = v.call;
  endtask

  task automatic model_reset();
    m_e = 1'b0; m_gt = 1'b0; m_lat = '0; m_bcnt = 32'd0; m_tcnt = 32'd0;
  endtask

  // One pipeline cycle: drive at posedge+1, check at the falling edge, advance model.
  task automatic cycle(input in_t v);
    logic fire, taken;
    logic [DATA_W-1:0] bpc;
    apply(v);
    #4;
    fire  = v.valid && !v.stall;
    taken = fire && (v.ub || (v.beq && m_e) || (v.bgt && m_gt));
    bpc   = v.ret ? v.op1 : v.tgt;
    s_taken = bus.branch_taken_o; s_bpc = bus.branch_pc_o;
    s_fe = bus.flags_e_o; s_fgt = bus.flags_gt_o; s_valid = bus.valid_o;
    s_call = bus.is_call_o; s_pc = bus.pc_o;
    s_bcnt = bus.branch_cnt_o; s_tcnt = bus.taken_cnt_o;
    chk("branch_taken", bus.branch_taken_o, taken);
    chk("flush", bus.flush_o, taken);
    chk("branch_pc", bus.branch_pc_o, bpc);
    chk("flags_e", bus.flags_e_o, m_e);
    chk("flags_gt", bus.flags_gt_o, m_gt);
    chk("valid_o", bus.valid_o, m_lat.valid);
    chk("pc_o", bus.pc_o, m_lat.pc);
    chk("alu_result_o", bus.alu_result_o, m_lat.res);
    chk("op2_o", bus.op2_o, m_lat.op2);
    chk("rd_o", bus.rd_o, m_lat.rd);
    chk("is_ld_o", bus.is_ld_o, m_lat.ld);
    chk("is_st_o", bus.is_st_o, m_lat.st);
    chk("is_wb_o", bus.is_wb_o, m_lat.wb);
    chk("is_call_o", bus.is_call_o, m_lat.call);
    chk("branch_cnt", bus.branch_cnt_o, m_bcnt);
    chk("taken_cnt", bus.taken_cnt_o, m_tcnt);
    if (fire && v.cmp) begin
      m_e = v.fe; m_gt = v.fgt;
    end
    if (!v.stall) begin
      m_lat = v;
      if (!v.valid) begin
        m_lat.ld = 1'b0; m_lat.st = 1'b0; m_lat.wb = 1'b0; m_lat.call = 1'b0;
      end
    end
`ifdef BRANCH_STATS_EN
    if (fire && (v.beq || v.bgt || v.ub)) m_bcnt = m_bcnt + 32'd1;
    if (taken) m_tcnt = m_tcnt + 32'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  function automatic in_t f_base(input logic [DATA_W-1:0] pc);
    in_t v = '0;
    v.valid = 1'b1; v.pc = pc;
    return v;
  endfunction
  function automatic in_t f_cmp(input logic [DATA_W-1:0] pc, input logic e, input logic gt);
    in_t v = f_base(pc);
    v.cmp = 1'b1; v.fe = e; v.fgt = gt;
    return v;
  endfunction
  function automatic in_t f_beq(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] t);
    in_t v = f_base(pc);
    v.beq = 1'b1; v.tgt = t;
    return v;
  endfunction
  function automatic in_t f_bgt(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] t);
    in_t v = f_base(pc);
    v.bgt = 1'b1; v.tgt = t;
    return v;
  endfunction
  function automatic in_t f_b(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] t);
    in_t v = f_base(pc);
    v.ub = 1'b1; v.tgt = t;
    return v;
  endfunction
  function automatic in_t f_ret(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] ra);
    in_t v = f_base(pc);
    v.ub = 1'b1; v.ret = 1'b1; v.op1 = ra;
    return v;
  endfunction
  function automatic in_t f_call(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] t);
    in_t v = f_base(pc);
    v.ub = 1'b1; v.call = 1'b1; v.wb = 1'b1; v.rd = c_ra_idx; v.tgt = t;
    return v;
  endfunction
  function automatic in_t f_add(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] r,
                                input logic [REG_W-1:0] rd);
    in_t v = f_base(pc);
    v.wb = 1'b1; v.res = r; v.rd = rd;
    return v;
  endfunction

  function automatic vec_t mk_vec(input in_t v, input logic tk, input logic [DATA_W-1:0] bpc,
                                  input logic fe, input logic fgt, input logic vld);
    vec_t r;
    r.stim = v; r.x_taken = tk; r.x_bpc = bpc; r.x_fe = fe; r.x_fgt = fgt; r.x_valid = vld;
    return r;
  endfunction

  initial begin
    in_t v;
    model_reset();
    apply('0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_flags_e", bus.flags_e_o, 0);
    chk("rst_flags_gt", bus.flags_gt_o, 0);
    chk("rst_pc_o", bus.pc_o, 0);
    reset = 1'b0;

    // Directed table: expected redirect and registered state seen in each row
    vecs[0] = mk_vec(f_cmp(32'h10, 1'b1, 1'b0),    1'b0, 32'h0,    1'b0, 1'b0, 1'b0);
    vecs[1] = mk_vec(f_beq(32'h14, 32'h40),        1'b1, 32'h40,   1'b1, 1'b0, 1'b1);
    vecs[2] = mk_vec(f_cmp(32'h18, 1'b0, 1'b0),    1'b0, 32'h0,    1'b1, 1'b0, 1'b1);
    vecs[3] = mk_vec(f_beq(32'h1C, 32'h50),        1'b0, 32'h50,   1'b0, 1'b0, 1'b1);
    vecs[4] = mk_vec(f_bgt(32'h20, 32'h60),        1'b0, 32'h60,   1'b0, 1'b0, 1'b1);
    vecs[5] = mk_vec(f_ret(32'h24, 32'h1234),      1'b1, 32'h1234, 1'b0, 1'b0, 1'b1);
    vecs[6] = mk_vec(f_call(32'h200, 32'h80),      1'b1, 32'h80,   1'b0, 1'b0, 1'b1);
    v = f_call(32'h204, 32'h70); v.valid = 1'b0;
    vecs[7] = mk_vec(v,                            1'b0, 32'h70,   1'b0, 1'b0, 1'b1);
    vecs[8] = mk_vec('0,                           1'b0, 32'h0,    1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].stim);
      chk($sformatf("tbl%0d_taken", i), s_taken, vecs[i].x_taken);
      chk($sformatf("tbl%0d_bpc", i), s_bpc, vecs[i].x_bpc);
      chk($sformatf("tbl%0d_fe", i), s_fe, vecs[i].x_fe);
      chk($sformatf("tbl%0d_fgt", i), s_fgt, vecs[i].x_fgt);
      chk($sformatf("tbl%0d_valid", i), s_valid, vecs[i].x_valid);
      if (i == 7) begin
        chk("call_is_call_o", s_call, 1);
        chk("call_pc_o", s_pc, 32'h200);
      end
      if (i == 8) chk("bubble_is_call_o", s_call, 0);
    end

    // Stalled cmp then stalled bgt
    cycle(f_add(32'h300, 32'hAA, 4'd3));
    v = f_cmp(32'h304, 1'b0, 1'b1); v.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(v);
      chk("stall_cmp_fgt", s_fgt, 0);
      chk("stall_cmp_pc_o", s_pc, 32'h300);
    end
    v.stall = 1'b0;
    cycle(v);
    chk("rel_cmp_fgt", s_fgt, 0);
    v = f_bgt(32'h308, 32'hC0); v.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(v);
      chk("stall_bgt_taken", s_taken, 0);
      chk("stall_bgt_fgt", s_fgt, 1);
      chk("stall_bgt_pc_o", s_pc, 32'h304);
    end
    v.stall = 1'b0;
    cycle(v);
    chk("rel_bgt_taken", s_taken, 1);
    chk("rel_bgt_bpc", s_bpc, 32'hC0);
    cycle('0);
    chk("bgt_pc_o", s_pc, 32'h308);

    // Reset asserted mid-cycle with a live call in EX
    apply(f_call(32'h400, 32'h90));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid_o", bus.valid_o, 0);
    chk("mid_rst_pc_o", bus.pc_o, 0);
    chk("mid_rst_flags_gt", bus.flags_gt_o, 0);
    chk("mid_rst_taken", bus.branch_taken_o, 0);
    chk("mid_rst_flush", bus.flush_o, 0);
    chk("mid_rst_bpc", bus.branch_pc_o, 0);
    chk("mid_rst_is_call_o", bus.is_call_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle('0);
    chk("post_rst_fe", s_fe, 0);
    chk("post_rst_fgt", s_fgt, 0);

    // Statistics: b, beq taken, bgt not taken, add
    cycle(f_cmp(32'h500, 1'b1, 1'b0));
    cycle(f_b(32'h504, 32'hA0));
    cycle(f_beq(32'h508, 32'hB0));
    cycle(f_bgt(32'h50C, 32'hC0));
    cycle(f_add(32'h510, 32'h5, 4'd1));
    cycle('0);
`ifdef BRANCH_STATS_EN
    chk("stats_branch_cnt", s_bcnt, 3);
    chk("stats_taken_cnt", s_tcnt, 2);
`else
    chk("stats_branch_cnt", s_bcnt, 0);
    chk("stats_taken_cnt", s_tcnt, 0);
`endif

    // Random instruction mix, including illegal cmp+branch overlap
    for (int n = 0; n < 400; n++) begin
      int kind;
      v = f_base($urandom);
      v.valid = ($urandom_range(0, 4) != 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.tgt = $urandom; v.op1 = $urandom; v.op2 = $urandom; v.res = $urandom;
      v.rd = 4'($urandom_range(0, 15));
      v.fe = 1'($urandom_range(0, 1)); v.fgt = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 8);
      case (kind)
        1: v.cmp = 1'b1;
        2: v.beq = 1'b1;
        3: v.bgt = 1'b1;
        4: v.ub = 1'b1;
        5: begin v.ub = 1'b1; v.call = 1'b1; v.wb = 1'b1; end
        6: begin v.ub = 1'b1; v.ret = 1'b1; end
        7: begin v.ld = 1'($urandom_range(0, 1)); v.st = ~v.ld; v.wb = v.ld; end
        8: begin v.cmp = 1'b1; v.beq = 1'($urandom_range(0, 1)); v.bgt = ~v.beq; end
        default: v.wb = 1'b1;
      endcase
      cycle(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
